// File: rtl/mem_stage.sv
// Memory access stage: forwards ALU results, runs load/store handshakes with
// the data memory, and reports misalignment and bus timeouts.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID_IN,
    input  logic [31:0] ALU_RESULT,
    input  logic [31:0] STORE_DATA,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
    input  logic [2:0]  FUNCT3,
    input  logic [4:0]  RD_IN,
    input  logic        REG_WR_IN,
    input  logic        CRT_WB_IN,
    output logic        STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    output logic        VALID_OUT,
    output logic [31:0] DATA_M,
    output logic [31:0] DATA_E,
    output logic        CRT_WB,
    output logic [4:0]  RD_OUT,
    output logic        REG_WR_OUT,
    output logic        MISALIGN,
    output logic        BUS_ERR
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;
    logic        pend_wr_q, pend_crt_q;
    logic        valid_q, crt_q, reg_wr_q, mis_q, berr_q;
    logic [31:0] data_m_q, data_e_q;
    logic [4:0]  rd_q;

    logic        is_mem, misal;
    logic [1:0]  sz;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_d;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign sz     = FUNCT3[1:0];
    assign is_mem = MEM_RD | MEM_WR;
    // Byte sizes are always aligned; halfwords need bit 0 clear, words both bits.
    assign misal  = ((sz == 2'b01) & ALU_RESULT[0]) |
                    (sz[1] & (|ALU_RESULT[1:0]));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = STORE_DATA;
        if (sz == 2'b00) begin
            be_d    = 4'b0001 << ALU_RESULT[1:0];
            wdata_d = {4{STORE_DATA[7:0]}};
        end else if (sz == 2'b01) begin
            be_d    = 4'b0011 << ALU_RESULT[1:0];
            wdata_d = {2{STORE_DATA[15:0]}};
        end
    end

    assign ld_b = DMEM_RDATA[{lane_q, 3'b000} +: 8];
    assign ld_h = DMEM_RDATA[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_d = DMEM_RDATA;
        case (f3_q)
            3'b000:  ld_d = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_d = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_d = {24'b0, ld_b};
            3'b101:  ld_d = {16'b0, ld_h};
            default: ld_d = DMEM_RDATA;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            lane_q     <= 2'd0;
            f3_q       <= 3'd0;
            pend_wr_q  <= 1'b0;
            pend_crt_q <= 1'b0;
            valid_q    <= 1'b0;
            crt_q      <= 1'b0;
            reg_wr_q   <= 1'b0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
            data_m_q   <= 32'd0;
            data_e_q   <= 32'd0;
            rd_q       <= 5'd0;
        end else begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    reg_wr_q <= 1'b0;
                    if (VALID_IN && !is_mem) begin
                        valid_q  <= 1'b1;
                        data_e_q <= ALU_RESULT;
                        crt_q    <= CRT_WB_IN;
                        rd_q     <= RD_IN;
                        reg_wr_q <= REG_WR_IN;
                    end else if (VALID_IN && misal) begin
                        mis_q <= 1'b1;
                    end else if (VALID_IN) begin
                        state_q    <= S_WAIT;
                        cnt_q      <= 8'd0;
                        req_q      <= 1'b1;
                        we_q       <= MEM_WR;
                        addr_q     <= {ALU_RESULT[31:2], 2'b00};
                        be_q       <= be_d;
                        wdata_q    <= wdata_d;
                        lane_q     <= ALU_RESULT[1:0];
                        f3_q       <= FUNCT3;
                        rd_q       <= RD_IN;
                        pend_wr_q  <= REG_WR_IN & ~MEM_WR;
                        pend_crt_q <= CRT_WB_IN;
                    end
                end
                S_WAIT: begin
                    if (DMEM_ACK) begin
                        state_q  <= S_IDLE;
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        valid_q  <= 1'b1;
                        reg_wr_q <= pend_wr_q;
                        crt_q    <= we_q ? pend_crt_q : 1'b0;
                        if (!we_q) data_m_q <= ld_d;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == 8'(TIMEOUT - 1)) begin
                            state_q <= S_IDLE;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            berr_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign STALL      = (state_q == S_WAIT);
    assign DMEM_REQ   = req_q;
    assign DMEM_WE    = we_q;
    assign DMEM_ADDR  = addr_q;
    assign DMEM_BE    = be_q;
    assign DMEM_WDATA = wdata_q;
    assign VALID_OUT  = valid_q;
    assign DATA_M     = data_m_q;
    assign DATA_E     = data_e_q;
    assign CRT_WB     = crt_q;
    assign RD_OUT     = rd_q;
    assign REG_WR_OUT = reg_wr_q;
    assign MISALIGN   = mis_q;
    assign BUS_ERR    = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback events are queued at
// drive time and matched against VALID_OUT/MISALIGN/BUS_ERR as they appear.
module tb_mem_stage;

    localparam int TO = 16;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_MIS = 3, K_BERR = 4;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwr;
        logic        crt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        VALID_IN = 1'b0;
    logic [31:0] ALU_RESULT = '0;
    logic [31:0] STORE_DATA = '0;
    logic        MEM_RD = 1'b0;
    logic        MEM_WR = 1'b0;
    logic [2:0]  FUNCT3 = '0;
    logic [4:0]  RD_IN = '0;
    logic        REG_WR_IN = 1'b0;
    logic        CRT_WB_IN = 1'b0;
    logic        DMEM_ACK = 1'b0;
    logic [31:0] DMEM_RDATA = '0;
    logic        STALL, DMEM_REQ, DMEM_WE, VALID_OUT, CRT_WB, REG_WR_OUT;
    logic        MISALIGN, BUS_ERR;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DATA_M, DATA_E;
    logic [3:0]  DMEM_BE;
    logic [4:0]  RD_OUT;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    mem_stage #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .ALU_RESULT(ALU_RESULT),
        .STORE_DATA(STORE_DATA), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .FUNCT3(FUNCT3), .RD_IN(RD_IN), .REG_WR_IN(REG_WR_IN),
        .CRT_WB_IN(CRT_WB_IN), .STALL(STALL), .DMEM_REQ(DMEM_REQ),
        .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
        .VALID_OUT(VALID_OUT), .DATA_M(DATA_M), .DATA_E(DATA_E),
        .CRT_WB(CRT_WB), .RD_OUT(RD_OUT), .REG_WR_OUT(REG_WR_OUT),
        .MISALIGN(MISALIGN), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3,
                                        input logic [1:0] lane);
        logic [3:0] be = '0;
        for (int i = 0; i < nbytes(f3); i++) be[int'(lane) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                         input logic [31:0] sd);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = sd[8*(j % nbytes(f3)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                         input logic [1:0] lane,
                                         input logic [31:0] rdata);
        logic [31:0] v = '0;
        int nb = nbytes(f3);
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(int'(lane) + i) +: 8];
        if (!f3[2] && nb < 4)
            for (int b = 8 * nb; b < 32; b++) v[b] = v[8*nb - 1];
        return v;
    endfunction

    // Output monitor: every result/pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && (VALID_OUT || MISALIGN || BUS_ERR)) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {29'b0, VALID_OUT, MISALIGN, BUS_ERR}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_kind", {29'b0, VALID_OUT, MISALIGN, BUS_ERR},
                    (mon_e.kind == K_MIS) ? 32'd2 :
                    (mon_e.kind == K_BERR) ? 32'd1 : 32'd4);
                if (mon_e.kind == K_ALU) begin
                    chk("alu_data_e", DATA_E, mon_e.data);
                    chk("alu_rd", 32'(RD_OUT), 32'(mon_e.rd));
                    chk("alu_regwr", 32'(REG_WR_OUT), 32'(mon_e.regwr));
                    chk("alu_crt", 32'(CRT_WB), 32'(mon_e.crt));
                end else if (mon_e.kind == K_LD) begin
                    chk("ld_data_m", DATA_M, mon_e.data);
                    chk("ld_rd", 32'(RD_OUT), 32'(mon_e.rd));
                    chk("ld_regwr", 32'(REG_WR_OUT), 32'(mon_e.regwr));
                    chk("ld_crt", 32'(CRT_WB), 32'd0);
                end else if (mon_e.kind == K_ST) begin
                    chk("st_regwr", 32'(REG_WR_OUT), 32'd0);
                end else begin
                    chk("pulse_valid", 32'(VALID_OUT), 32'd0);
                end
            end
        end
    end

    task automatic alu_op(input logic [31:0] res, input logic [4:0] rd,
                          input logic regwr, input logic crt);
        VALID_IN = 1'b1; MEM_RD = 1'b0; MEM_WR = 1'b0;
        ALU_RESULT = res; RD_IN = rd; REG_WR_IN = regwr; CRT_WB_IN = crt;
        sb.push_back('{K_ALU, res, rd, regwr, crt});
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        chk("alu_stall", 32'(STALL), 32'd0);
        @(posedge CLK); #1;
        chk("idle_valid", 32'(VALID_OUT), 32'd0);
        chk("idle_regwr", 32'(REG_WR_OUT), 32'd0);
    endtask

    task automatic mis_op(input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr);
        VALID_IN = 1'b1; MEM_RD = ~wr; MEM_WR = wr; FUNCT3 = f3;
        ALU_RESULT = addr; REG_WR_IN = 1'b1;
        sb.push_back('{K_MIS, 32'd0, 5'd0, 1'b0, 1'b0});
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        chk("mis_req", 32'(DMEM_REQ), 32'd0);
        chk("mis_stall", 32'(STALL), 32'd0);
        @(posedge CLK); #1;
        chk("mis_pulse_end", 32'(MISALIGN), 32'd0);
    endtask

    // ack_at: WAIT cycle (1-based) that carries ACK; 0 means never.
    task automatic mem_op(input logic rd_en, input logic wr_en,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rdata,
                          input int ack_at, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] eld);
        int n = 0;
        logic [4:0] rd = 5'($urandom_range(1, 31));
        logic crt = 1'($urandom);
        VALID_IN = 1'b1; MEM_RD = rd_en; MEM_WR = wr_en; FUNCT3 = f3;
        ALU_RESULT = addr; STORE_DATA = sd; RD_IN = rd;
        REG_WR_IN = 1'b1; CRT_WB_IN = crt;
        if (ack_at == 0)      sb.push_back('{K_BERR, 32'd0, 5'd0, 1'b0, 1'b0});
        else if (wr_en)       sb.push_back('{K_ST, 32'd0, rd, 1'b0, crt});
        else                  sb.push_back('{K_LD, eld, rd, 1'b1, 1'b0});
        @(posedge CLK); #1;
        chk("req_on", 32'(DMEM_REQ), 32'd1);
        while (DMEM_REQ && n < 64) begin
            n++;
            chk("wait_stall", 32'(STALL), 32'd1);
            chk("wait_valid", 32'(VALID_OUT), 32'd0);
            chk("wait_addr", DMEM_ADDR, {addr[31:2], 2'b00});
            chk("wait_we", 32'(DMEM_WE), 32'(wr_en));
            if (wr_en) begin
                chk("wait_be", 32'(DMEM_BE), 32'(ebe));
                chk("wait_wdata", DMEM_WDATA, ewd);
            end
            // Noise on the upstream bus must be ignored while waiting.
            VALID_IN = 1'b1; MEM_RD = 1'($urandom); MEM_WR = 1'($urandom);
            ALU_RESULT = $urandom; STORE_DATA = $urandom;
            DMEM_ACK = (n == ack_at);
            DMEM_RDATA = (n == ack_at) ? rdata : $urandom;
            @(posedge CLK); #1;
            DMEM_ACK = 1'b0;
            VALID_IN = 1'b0; MEM_RD = 1'b0; MEM_WR = 1'b0;
        end
        chk("wait_cycles", 32'(n), (ack_at == 0) ? 32'(TO) : 32'(ack_at));
        chk("req_drop", 32'(DMEM_REQ), 32'd0);
        chk("stall_drop", 32'(STALL), 32'd0);
        @(posedge CLK); #1;
        chk("valid_pulse_end", 32'(VALID_OUT), 32'd0);
        chk("berr_pulse_end", 32'(BUS_ERR), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_valid", 32'(VALID_OUT), 32'd0);
        chk("rst_req", 32'(DMEM_REQ), 32'd0);
        chk("rst_stall", 32'(STALL), 32'd0);
        chk("rst_data_e", DATA_E, 32'd0);
        chk("rst_regwr", 32'(REG_WR_OUT), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        DMEM_ACK = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_ack_req", 32'(DMEM_REQ), 32'd0);
        chk("idle_ack_stall", 32'(STALL), 32'd0);
        DMEM_ACK = 1'b0;

        alu_op(32'h0000_1234, 5'd5, 1'b1, 1'b1);
        alu_op(32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            VALID_IN = 1'b1; MEM_RD = 1'b0; MEM_WR = 1'b0;
            ALU_RESULT = 32'h100 * i + 32'h7; RD_IN = 5'(i + 1);
            REG_WR_IN = 1'b1; CRT_WB_IN = 1'b1;
            sb.push_back('{K_ALU, 32'h100 * i + 32'h7, 5'(i + 1), 1'b1, 1'b1});
            @(posedge CLK); #1;
            chk("burst_stall", 32'(STALL), 32'd0);
        end
        VALID_IN = 1'b0;
        @(posedge CLK); #1;

        mem_op(1, 0, 3'b000, 32'h103, 0, 32'h80FF_FF7F, 3, 4'b1000, 0, 32'hFFFF_FF80);
        mem_op(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 1, 4'b1100, 32'hABCD_ABCD, 0);
        mem_op(0, 1, 3'b000, 32'h101, 32'h1234_565A, 0, 2, 4'b0010, 32'h5A5A_5A5A, 0);
        mem_op(0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 1, 4'b1111, 32'hCAFE_F00D, 0);
        mem_op(1, 1, 3'b010, 32'h304, 32'h0BAD_CAFE, 0, 2, 4'b1111, 32'h0BAD_CAFE, 0);
        mem_op(1, 0, 3'b101, 32'h402, 0, 32'h8001_7FFF, 1, 0, 0, 32'h0000_8001);
        mem_op(1, 0, 3'b001, 32'h400, 0, 32'h8001_7FFF, 2, 0, 0, 32'h0000_7FFF);
        mem_op(1, 0, 3'b001, 32'h402, 0, 32'h8001_7FFF, 1, 0, 0, 32'hFFFF_8001);
        mem_op(1, 0, 3'b100, 32'h401, 0, 32'h0000_8000, 1, 0, 0, 32'h0000_0080);
        mem_op(1, 0, 3'b111, 32'h500, 0, 32'h1357_9BDF, 1, 0, 0, 32'h1357_9BDF);
        mem_op(1, 0, 3'b010, 32'h040, 0, 0, 0, 0, 0, 0);
        mem_op(1, 0, 3'b010, 32'h044, 0, 32'h2468_ACE0, TO, 0, 0, 32'h2468_ACE0);

        mis_op(1'b0, 3'b010, 32'h005);
        mis_op(1'b1, 3'b001, 32'h203);
        mis_op(1'b0, 3'b101, 32'h011);

        // Reset lands in the second WAIT cycle together with ACK.
        VALID_IN = 1'b1; MEM_RD = 1'b1; MEM_WR = 1'b0; FUNCT3 = 3'b010;
        ALU_RESULT = 32'h600; REG_WR_IN = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0; MEM_RD = 1'b0;
        chk("rstw_req1", 32'(DMEM_REQ), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1; DMEM_ACK = 1'b1; DMEM_RDATA = 32'h5555_AAAA;
        @(posedge CLK); #1;
        RST = 1'b0; DMEM_ACK = 1'b0;
        chk("rstw_req", 32'(DMEM_REQ), 32'd0);
        chk("rstw_stall", 32'(STALL), 32'd0);
        chk("rstw_valid", 32'(VALID_OUT), 32'd0);
        @(posedge CLK); #1;
        chk("rstw_valid2", 32'(VALID_OUT), 32'd0);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  f3;
            logic        wr;
            logic [31:0] a, sd, rdat;
            int          ack;
            wr   = 1'($urandom);
            f3   = wr ? 3'($urandom_range(0, 2)) : 3'($urandom);
            a    = $urandom & ~(32'(nbytes(f3)) - 32'd1);
            sd   = $urandom;
            rdat = $urandom;
            ack  = $urandom_range(1, 4);
            mem_op(~wr, wr, f3, a, sd, rdat, ack, m_be(f3, a[1:0]),
                   m_wd(f3, sd), m_ld(f3, a[1:0], rdat));
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
